ifm_byte_reader: RTL and testbench

// - Read-side counterpart of the byte-addressed feature-map store.
// - Fetches packed 32-bit words from a synchronous-read feature-map memory.
// - Unpacks each word into bytes, MSB lane first: offset 0 = [31:24], offset 3 = [7:0].
// - Streams the bytes to the PE array over valid/ready, tagged with word address and offset.

---
 rtl/fm_pkg.sv | 33 +++
 rtl/fm_word_fifo2.sv | 50 +++++
 rtl/ifm_byte_reader.sv | 121 ++++++++++++
 tb/tb_ifm_byte_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fm_pkg.sv
// Shared types and helpers for the feature-map byte reader: sizes, lane type,
// FSM states, MSB-first lane select and wrapping word-address increment.
package fm_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 10;

    typedef logic [1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Lane 0 is the most significant byte of the packed word.
    function automatic logic [BYTE_W-1:0] byte_of(input logic [WORD_W-1:0] word, input lane_t lane);
        case (lane)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
        return (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;
    endfunction

endpackage

// File: rtl/fm_word_fifo2.sv
// Two-entry buffer of fetched words and their addresses; the head entry feeds
// the byte unpacker. The caller guarantees no push when full and no pop when empty.
module fm_word_fifo2
    import fm_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_push_data,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic              i_pop,
    output logic [WORD_W-1:0] o_head_data,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [1:0]        o_count
);

    logic [WORD_W-1:0] r_data [2];
    logic [ADDR_W-1:0] r_addr [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: storage is only two entries, so it is reset to keep byte outputs at 0 out of reset.
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_addr[0] <= '0;
            r_addr[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (i_push) begin
                r_data[r_wr_ptr] <= i_push_data;
                r_addr[r_wr_ptr] <= i_push_addr;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head_data = r_data[r_rd_ptr];
    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_count     = r_count;

endmodule

// File: rtl/ifm_byte_reader.sv
// Fetches packed words from a synchronous-read feature-map memory and streams
// them MSB lane first as valid/ready bytes tagged with word address and lane.
module ifm_byte_reader
    import fm_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_num_bytes,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [WORD_W-1:0] i_mem_rdata,
    output logic              o_byte_valid,
    input  logic              i_byte_ready,
    output logic [BYTE_W-1:0] o_byte_data,
    output logic [ADDR_W-1:0] o_byte_addr,
    output logic [1:0]        o_byte_offset
);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [LEN_W-1:0]  r_words_left;
    logic [LEN_W-1:0]  r_bytes_left;
    logic              r_rd_pend;
    lane_t             r_lane;

    logic [LEN_W:0]    w_words_needed;
    logic              w_accept;
    logic              w_issue;
    logic              w_hs;
    logic              w_last;
    logic              w_pop;
    logic [WORD_W-1:0] w_head_data;
    logic [ADDR_W-1:0] w_head_addr;
    logic [1:0]        w_count;

    assign w_words_needed = ({1'b0, i_num_bytes} + (LEN_W + 1)'(3)) >> 2;
    assign w_accept       = (r_state == IDLE) && i_start;
    // Buffered plus in-flight words never exceed the two buffer slots.
    assign w_issue        = (r_state == RUN) && (r_words_left != '0)
                            && ((w_count + {1'b0, r_rd_pend}) < 2'd2);
    assign o_byte_valid   = (r_state == RUN) && (w_count != 2'd0);
    assign w_hs           = o_byte_valid && i_byte_ready;
    assign w_last         = (r_bytes_left == LEN_W'(1));
    // The last byte also retires its word, discarding any unused lanes.
    assign w_pop          = w_hs && (w_last || (r_lane == 2'd3));

    fm_word_fifo2 u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (r_rd_pend),
        .i_push_data (i_mem_rdata),
        .i_push_addr (r_pend_addr),
        .i_pop       (w_pop),
        .o_head_data (w_head_data),
        .o_head_addr (w_head_addr),
        .o_count     (w_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_next_state = (i_num_bytes == '0) ? FIN : RUN;
            RUN:     if (w_hs && w_last) w_next_state = FIN;
            FIN:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_addr <= '0;
            r_pend_addr  <= '0;
            r_words_left <= '0;
            r_bytes_left <= '0;
            r_rd_pend    <= 1'b0;
            r_lane       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_rd_pend <= w_issue;
            if (w_accept) begin
                r_fetch_addr <= i_base_addr;
                r_words_left <= w_words_needed[LEN_W-1:0];
                r_bytes_left <= i_num_bytes;
                r_lane       <= '0;
            end
            if (w_issue) begin
                r_pend_addr  <= r_fetch_addr;
                r_fetch_addr <= next_addr(r_fetch_addr);
                r_words_left <= r_words_left - 1'b1;
            end
            if (w_hs) begin
                r_bytes_left <= r_bytes_left - 1'b1;
                r_lane       <= w_last ? lane_t'(0) : r_lane + 1'b1;
            end
        end
    end

    assign o_busy        = (r_state != IDLE);
    assign o_done        = (r_state == FIN);
    assign o_mem_rd_en   = w_issue;
    assign o_mem_addr    = r_fetch_addr;
    assign o_byte_data   = byte_of(w_head_data, r_lane);
    assign o_byte_addr   = w_head_addr;
    assign o_byte_offset = r_lane;

endmodule

// File: tb/tb_ifm_byte_reader.sv
// Self-checking bench for ifm_byte_reader: directed vector table, reset corner,
// and randomized transfers scored against a byte-list model built from memory.
module tb_ifm_byte_reader;
    import fm_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  num_bytes = '0;
    logic              busy, done, mem_rd_en, byte_valid;
    logic              byte_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr, byte_addr;
    logic [WORD_W-1:0] mem_rdata = '0;
    logic [BYTE_W-1:0] byte_data;
    logic [1:0]        byte_offset;

    always #5 clk = ~clk;

    ifm_byte_reader dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_base_addr   (base_addr),
        .i_num_bytes   (num_bytes),
        .o_busy        (busy),
        .o_done        (done),
        .o_mem_rd_en   (mem_rd_en),
        .o_mem_addr    (mem_addr),
        .i_mem_rdata   (mem_rdata),
        .o_byte_valid  (byte_valid),
        .i_byte_ready  (byte_ready),
        .o_byte_data   (byte_data),
        .o_byte_addr   (byte_addr),
        .o_byte_offset (byte_offset)
    );

    logic [31:0] mem [DEPTH];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr[6:0]];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] data;
        logic [7:0] addr;
        logic [1:0] off;
    } exp_t;

    typedef struct {
        logic [7:0] base;
        int         nbytes;
        int         mode;       // 0: ready always, 1: pattern 1,0,0,1, 2: random
        int         extra_cyc;  // cycle of a start pulse while busy, -1 for none
        int         exp_reads;
        logic [7:0] exp_first;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_vector();
        return {2'b0, busy, done, mem_rd_en, mem_addr, byte_valid, byte_data, byte_addr, byte_offset};
    endfunction

    task automatic run_xfer(input logic [7:0] base, input int nb, input int mode, input int extra_cyc,
                            input int exp_reads, input logic [7:0] exp_first, input string name);
        exp_t       q[$];
        exp_t       e;
        int         a, rd_n, cyc, hs_n, first_valid, first_rd, last_hs, done_cyc;
        logic [7:0] first_byte, s_data, s_addr;
        logic [1:0] s_off;
        logic       stalled;
        rd_n = 0; cyc = 0; hs_n = 0; first_valid = -1; first_rd = -1; last_hs = -1; done_cyc = -1;
        first_byte = '0; s_data = '0; s_addr = '0; s_off = '0; stalled = 1'b0;

        // Model: byte i is lane i%4 of word (base + i/4) mod DEPTH, MSB lane first.
        for (int i = 0; i < nb; i++) begin
            a = (int'(base) + i / 4) % DEPTH;
            e.data = 8'(mem[a] >> (8 * (3 - i % 4)));
            e.addr = 8'(a);
            e.off  = 2'(i % 4);
            q.push_back(e);
        end

        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_bytes = LEN_W'(nb);
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " busy_after_start"}, 32'(busy), 32'd1);

        while (done_cyc < 0 && cyc < 3000) begin
            if (cyc == extra_cyc) begin
                start = 1'b1; base_addr = 8'h40; num_bytes = 10'd16;
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       byte_ready = 1'b1;
                1:       byte_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: byte_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (mem_rd_en) begin
                check({name, " rd_addr"}, 32'(mem_addr), 32'((int'(base) + rd_n) % DEPTH));
                if (first_rd < 0) first_rd = cyc;
                rd_n++;
            end
            if (stalled) begin
                check({name, " stall_valid"}, 32'(byte_valid), 32'd1);
                check({name, " stall_data"},  32'(byte_data),  32'(s_data));
                check({name, " stall_addr"},  32'(byte_addr),  32'(s_addr));
                check({name, " stall_off"},   32'(byte_offset), 32'(s_off));
            end
            stalled = 1'b0;
            if (byte_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (byte_ready) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL %s extra_byte: got byte 0x%0h beyond %0d expected", name, byte_data, nb);
                    end else begin
                        e = q.pop_front();
                        if (hs_n == 0) first_byte = byte_data;
                        check({name, " data"}, 32'(byte_data),   32'(e.data));
                        check({name, " addr"}, 32'(byte_addr),   32'(e.addr));
                        check({name, " off"},  32'(byte_offset), 32'(e.off));
                        if (mode == 0) check({name, " no_bubble"}, 32'(cyc), 32'(first_valid + hs_n));
                        hs_n++;
                        last_hs = cyc;
                    end
                end else begin
                    stalled = 1'b1;
                    s_data = byte_data; s_addr = byte_addr; s_off = byte_offset;
                end
            end
            if (done) done_cyc = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;

        check({name, " done_seen"}, 32'(done_cyc >= 0), 32'd1);
        check({name, " bytes_missing"}, 32'(q.size()), 32'd0);
        check({name, " reads"}, 32'(rd_n), 32'(exp_reads));
        check({name, " done_timing"}, 32'(done_cyc), 32'((nb == 0) ? 0 : last_hs + 1));
        if (nb > 0 && mode == 0) begin
            check({name, " rd_latency"}, 32'(first_rd), 32'd0);
            check({name, " valid_latency"}, 32'(first_valid), 32'd2);
            check({name, " first_byte"}, 32'(first_byte), 32'(exp_first));
        end
        @(negedge clk);
        check({name, " idle_after_done"}, 32'({busy, done, mem_rd_en, byte_valid}), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t       vecs[7];
        int         hs, cyc, nb;
        logic [7:0] base;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
        mem['h10] = 32'hAABBCCDD;
        mem['h11] = 32'h11223344;
        mem['h7F] = 32'h5A6B7C8D;
        mem['h20] = 32'hC0DE0001;
        mem['h70] = 32'h01020304;

        vecs[0] = '{8'h10, 8,   0, -1, 2,   8'hAA};  // two full words
        vecs[1] = '{8'h10, 5,   0, -1, 2,   8'hAA};  // partial last word
        vecs[2] = '{8'h7F, 8,   0, -1, 2,   8'h5A};  // address wrap
        vecs[3] = '{8'h10, 12,  1, -1, 3,   8'hAA};  // backpressure pattern
        vecs[4] = '{8'h10, 0,   0, -1, 0,   8'h00};  // zero length
        vecs[5] = '{8'h20, 4,   0, 1,  1,   8'hC0};  // start ignored while busy
        vecs[6] = '{8'h70, 512, 0, -1, 128, 8'h01};  // maximum transfer

        #1;
        check("reset_outputs_async", out_vector(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_held", out_vector(), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i].base, vecs[i].nbytes, vecs[i].mode, vecs[i].extra_cyc,
                     vecs[i].exp_reads, vecs[i].exp_first, $sformatf("vec%0d", i));
        end

        // Reset asserted while byte 3 of 8 is presented.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'h20; num_bytes = 10'd8; byte_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hs = 0; cyc = 0;
        while (hs < 2 && cyc < 50) begin
            @(negedge clk);
            if (byte_valid && byte_ready) hs++;
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_mid_reached_byte3", 32'(byte_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs_async", out_vector(), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_no_done", 32'({done, busy}), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_xfer(8'h30, 6, 0, -1, 2, mem['h30][31:24], "after_reset");

        for (int t = 0; t < 25; t++) begin
            base = 8'($urandom_range(0, DEPTH - 1));
            nb   = int'($urandom_range(1, 40));
            run_xfer(base, nb, 2, -1, (nb + 3) / 4, 8'(mem[base[6:0]] >> 24), $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
